// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: column/row counters with combinational sync,
// blanking, active-video and line/frame strobe decode.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] column,
    output logic [CNT_W-1:0] row,
    output logic             hsync,
    output logic             vsync,
    output logic             rgb_en,
    output logic             vblank,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    // Widths of 31 and above always cover any int-sized total.
    localparam bit CNT_OK = (CNT_W >= 31) || ((CNT_W >= 1) && ((1 << CNT_W) > MAX_TOTAL));
    localparam bit PARAMS_OK = (H_ACTIVE >= 1) && (H_FP >= 1) && (H_SYNC >= 1) && (H_BP >= 1) &&
                               (V_ACTIVE >= 1) && (V_FP >= 1) && (V_SYNC >= 1) && (V_BP >= 1);

    generate
        if (!CNT_OK) begin : g_bad_width
            $fatal(1, "vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
        end
        if (!PARAMS_OK) begin : g_bad_timing
            $fatal(1, "vga_timing_gen: every timing parameter must be >= 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic h_in_sync;
    logic v_in_sync;
    logic at_line_origin;

    always_ff @(posedge clk) begin
        if (!rst) begin
            column <= '0;
            row    <= '0;
        end else if (pix_ce) begin
            if (column == H_LAST) begin
                column <= '0;
                row    <= (row == V_LAST) ? '0 : row + 1'b1;
            end else begin
                column <= column + 1'b1;
            end
        end
    end

    // All decode works on the registered counters so outputs stay aligned to column/row.
    assign h_in_sync      = (column >= H_SYNC_BEG) && (column <= H_SYNC_LAST);
    assign v_in_sync      = (row >= V_SYNC_BEG) && (row <= V_SYNC_LAST);
    assign at_line_origin = (column == '0);

    assign hsync       = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
    assign vsync       = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
    assign rgb_en      = (column < H_ACT_END) && (row < V_ACT_END);
    assign vblank      = (row >= V_ACT_END);
    assign line_start  = pix_ce && at_line_origin;
    assign frame_start = pix_ce && at_line_origin && (row == '0);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; next generation of the single-axis horizontal sync counter.
- Generates horizontal and vertical counters, hsync/vsync with configurable polarity, the active-video enable, blanking, and line/frame strobes.
- Sits between the pixel clock domain and the VGA framebuffer/pixel pipeline. column/row address pixel memory; rgb_en gates the DAC outputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)
- CNT_W, 11, width of the column and row counters

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset (reset applies when rst=0 at a clk edge)
- pix_ce  input  1  pixel clock enable; the raster advances only on cycles with pix_ce=1
- column  output  CNT_W  current horizontal position, 0..H_TOTAL-1
- row  output  CNT_W  current vertical position, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per HSYNC_POL
- vsync  output  1  vertical sync, polarity per VSYNC_POL
- rgb_en  output  1  high when the current pixel is visible
- vblank  output  1  high when the current line is in vertical blanking
- line_start  output  1  one-cycle strobe at the start of each line
- frame_start  output  1  one-cycle strobe at the start of each frame

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Elaboration check: 2^CNT_W > max(H_TOTAL, V_TOTAL). Also every timing parameter must be >= 1. Violating either is a fatal elaboration error.
- Storage is column and row registers only. All other outputs decode combinationally from the registered column/row (plus pix_ce for the strobes), so every output is cycle-aligned to column/row. Outputs are glitch-free only as far as decode allows; the downstream pad stage re-registers them.
- Reset (rst=0 at posedge): on the next cycle column=0 and row=0. Applies identically mid-line or mid-frame, with no partial-state retention.
- Values while and immediately after reset: rgb_en=1, vblank=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL. line_start and frame_start equal pix_ce.
- Advance, on a cycle with pix_ce=1 and rst=1:
  - If column==H_TOTAL-1: column<=0. Then, if row==V_TOTAL-1, row<=0; otherwise row<=row+1.
  - Otherwise: column<=column+1 and row holds.
- pix_ce=0: column and row hold; decoded levels hold; strobes are 0.
- Counters never reach H_TOTAL or V_TOTAL. There is no off-by-one terminal state: the line is exactly H_TOTAL pixels and the frame exactly V_TOTAL lines.
- rgb_en = (column < H_ACTIVE) && (row < V_ACTIVE).
- vblank = (row >= V_ACTIVE).
- hsync active level when H_ACTIVE+H_FP <= column <= H_ACTIVE+H_FP+H_SYNC-1 (default 656..751); inactive otherwise.
- vsync active level when V_ACTIVE+V_FP <= row <= V_ACTIVE+V_FP+V_SYNC-1 (default 490..491), for whole lines; inactive otherwise.
- line_start = pix_ce && (column==0).
- frame_start = pix_ce && (column==0) && (row==0). Simultaneous with line_start at the frame origin.
- Throughput: one pixel per pix_ce cycle; no added latency between the counters and the decoded outputs.

Test Plan:
- Reset: hold rst=0 for 3 cycles with pix_ce=1, then release. Required: column=0, row=0, hsync=1, vsync=1, rgb_en=1, frame_start=1 on the first cycle after release.
- Horizontal window, defaults, pix_ce=1 constant. Required: hsync=1 at column 655, 0 at 656 through 751, 1 at 752. rgb_en=1 at column 639 and 0 at 640. Column 799 is followed by 0, and row increments exactly once.
- Vertical and frame. Required: vsync=0 only for rows 490–491. vblank=1 from row 480 through 524. Row 524 wraps to 0. frame_start pulses exactly every 420000 cycles, and line_start every 800 cycles.
- pix_ce toggling 1,0,1,0. Required: column advances every other cycle; frame period becomes 840000 cycles; strobes appear only on pix_ce=1 cycles.
- Small config (H 4/1/2/1, V 3/1/1/1, HSYNC_POL=1, VSYNC_POL=1). Required: H_TOTAL=8 and V_TOTAL=6; hsync=1 at columns 5–6 only; vsync=1 on row 4 only; full frame takes 48 cycles.
- Mid-frame reset at column=300, row=200: assert rst=0 for 1 cycle. Required: next cycle column=0 and row=0; frame_start=1 when pix_ce=1; normal counting resumes after that.
